l2_request_arbiter: RTL and testbench



---
 rtl/l2_request_arbiter.sv | 157 +++++++++++++++
 tb/tb_l2_request_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_request_arbiter.sv
// Round-robin arbiter that shares one L2 request/response port between the instruction and data L1s.
// Define L2_ARBITER_PERF_EN to add grant and contention counters.
package l2_request_arbiter_pkg;
    typedef enum logic {Load = 1'b0, Store = 1'b1} memory_operation_e;
endpackage

module l2_request_arbiter
    import l2_request_arbiter_pkg::*;
#(
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,

    output logic                  l1i_request_ready_out,
    input  logic                  l1i_request_valid_in,
    input  logic [ADDR_WIDTH-1:0] l1i_request_address_in,
    input  memory_operation_e     l1i_request_operation_in,
    input  logic [LINE_WIDTH-1:0] l1i_request_data_in,
    input  logic                  l1i_response_ready_in,
    output logic                  l1i_response_valid_out,
    output logic [LINE_WIDTH-1:0] l1i_response_data_out,

    output logic                  l1d_request_ready_out,
    input  logic                  l1d_request_valid_in,
    input  logic [ADDR_WIDTH-1:0] l1d_request_address_in,
    input  memory_operation_e     l1d_request_operation_in,
    input  logic [LINE_WIDTH-1:0] l1d_request_data_in,
    input  logic                  l1d_response_ready_in,
    output logic                  l1d_response_valid_out,
    output logic [LINE_WIDTH-1:0] l1d_response_data_out,

    input  logic                  l2_cache_request_ready_in,
    output logic                  l2_cache_request_valid_out,
    output logic [ADDR_WIDTH-1:0] l2_cache_request_address_out,
    output memory_operation_e     l2_cache_request_operation_out,
    output logic [LINE_WIDTH-1:0] l2_cache_request_data_out,
    output logic                  l2_cache_response_ready_out,
    input  logic                  l2_cache_response_valid_in,
    input  logic [LINE_WIDTH-1:0] l2_cache_response_data_in
`ifdef L2_ARBITER_PERF_EN
    ,
    output logic [31:0]           l1i_grant_count_out,
    output logic [31:0]           l1d_grant_count_out,
    output logic [31:0]           contention_count_out
`endif
);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitResp, StRespond} state_e;

    state_e                state_q;
    logic                  grant_q;
    logic                  prio_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    memory_operation_e     op_q;
    logic [LINE_WIDTH-1:0] data_q;
    logic [LINE_WIDTH-1:0] line_q;

    logic both_valid;
    logic any_valid;
    logic sel;
    logic idle;
    logic granted_rsp_ready;

    assign both_valid = l1i_request_valid_in & l1d_request_valid_in;
    assign any_valid  = l1i_request_valid_in | l1d_request_valid_in;
    // sel = 1 picks the data L1; prio_q only matters under contention
    assign sel        = both_valid ? prio_q : l1d_request_valid_in;
    assign idle       = (state_q == StIdle) && !rst_in;

    assign l1i_request_ready_out = idle & l1i_request_valid_in & ~sel;
    assign l1d_request_ready_out = idle & l1d_request_valid_in & sel;

    assign granted_rsp_ready = grant_q ? l1d_response_ready_in : l1i_response_ready_in;

`ifdef L2_ARBITER_PERF_EN
    logic [31:0] l1i_count_q;
    logic [31:0] l1d_count_q;
    logic [31:0] contention_count_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            l1i_count_q        <= '0;
            l1d_count_q        <= '0;
            contention_count_q <= '0;
        end else if (state_q == StIdle && any_valid) begin
            if (sel) l1d_count_q <= l1d_count_q + 32'd1;
            else     l1i_count_q <= l1i_count_q + 32'd1;
            if (both_valid) contention_count_q <= contention_count_q + 32'd1;
        end
    end

    assign l1i_grant_count_out  = l1i_count_q;
    assign l1d_grant_count_out  = l1d_count_q;
    assign contention_count_out = contention_count_q;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            grant_q <= 1'b0;
            prio_q  <= 1'b0;
            addr_q  <= '0;
            op_q    <= Load;
            data_q  <= '0;
            line_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        grant_q <= sel;
                        addr_q  <= sel ? l1d_request_address_in : l1i_request_address_in;
                        op_q    <= sel ? l1d_request_operation_in : l1i_request_operation_in;
                        data_q  <= sel ? l1d_request_data_in : l1i_request_data_in;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (l2_cache_request_ready_in) begin
                        if (op_q == Store) begin
                            prio_q  <= ~grant_q;
                            state_q <= StIdle;
                        end else begin
                            state_q <= StWaitResp;
                        end
                    end
                end
                StWaitResp: begin
                    if (l2_cache_response_valid_in) begin
                        line_q  <= l2_cache_response_data_in;
                        state_q <= StRespond;
                    end
                end
                StRespond: begin
                    if (granted_rsp_ready) begin
                        prio_q  <= ~grant_q;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign l2_cache_request_valid_out     = (state_q == StIssue);
    assign l2_cache_request_address_out   = addr_q;
    assign l2_cache_request_operation_out = op_q;
    assign l2_cache_request_data_out      = data_q;
    assign l2_cache_response_ready_out    = (state_q == StWaitResp);

    assign l1i_response_valid_out = (state_q == StRespond) && !grant_q;
    assign l1d_response_valid_out = (state_q == StRespond) && grant_q;
    assign l1i_response_data_out  = l1i_response_valid_out ? line_q : '0;
    assign l1d_response_data_out  = l1d_response_valid_out ? line_q : '0;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Scoreboard bench for l2_request_arbiter: expected grants, L2 requests and L1 responses are
// queued by the stimulus and retired by a negedge monitor.
module tb_l2_request_arbiter;
    import l2_request_arbiter_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic              l1i_request_ready_out, l1d_request_ready_out;
    logic              l1i_request_valid_in = 1'b0, l1d_request_valid_in = 1'b0;
    logic [31:0]       l1i_request_address_in = '0, l1d_request_address_in = '0;
    memory_operation_e l1i_request_operation_in = Load, l1d_request_operation_in = Load;
    logic [127:0]      l1i_request_data_in = '0, l1d_request_data_in = '0;
    logic              l1i_response_ready_in = 1'b1, l1d_response_ready_in = 1'b1;
    logic              l1i_response_valid_out, l1d_response_valid_out;
    logic [127:0]      l1i_response_data_out, l1d_response_data_out;
    logic              l2_cache_request_ready_in = 1'b1;
    logic              l2_cache_request_valid_out;
    logic [31:0]       l2_cache_request_address_out;
    memory_operation_e l2_cache_request_operation_out;
    logic [127:0]      l2_cache_request_data_out;
    logic              l2_cache_response_ready_out;
    logic              l2_cache_response_valid_in = 1'b0;
    logic [127:0]      l2_cache_response_data_in = '0;
`ifdef L2_ARBITER_PERF_EN
    logic [31:0]       l1i_grant_count_out, l1d_grant_count_out, contention_count_out;
`endif

    l2_request_arbiter dut (
        .clk_in                         (clk_in),
        .rst_in                         (rst_in),
        .l1i_request_ready_out          (l1i_request_ready_out),
        .l1i_request_valid_in           (l1i_request_valid_in),
        .l1i_request_address_in         (l1i_request_address_in),
        .l1i_request_operation_in       (l1i_request_operation_in),
        .l1i_request_data_in            (l1i_request_data_in),
        .l1i_response_ready_in          (l1i_response_ready_in),
        .l1i_response_valid_out         (l1i_response_valid_out),
        .l1i_response_data_out          (l1i_response_data_out),
        .l1d_request_ready_out          (l1d_request_ready_out),
        .l1d_request_valid_in           (l1d_request_valid_in),
        .l1d_request_address_in         (l1d_request_address_in),
        .l1d_request_operation_in       (l1d_request_operation_in),
        .l1d_request_data_in            (l1d_request_data_in),
        .l1d_response_ready_in          (l1d_response_ready_in),
        .l1d_response_valid_out         (l1d_response_valid_out),
        .l1d_response_data_out          (l1d_response_data_out),
        .l2_cache_request_ready_in      (l2_cache_request_ready_in),
        .l2_cache_request_valid_out     (l2_cache_request_valid_out),
        .l2_cache_request_address_out   (l2_cache_request_address_out),
        .l2_cache_request_operation_out (l2_cache_request_operation_out),
        .l2_cache_request_data_out      (l2_cache_request_data_out),
        .l2_cache_response_ready_out    (l2_cache_response_ready_out),
        .l2_cache_response_valid_in     (l2_cache_response_valid_in),
        .l2_cache_response_data_in      (l2_cache_response_data_in)
`ifdef L2_ARBITER_PERF_EN
        ,
        .l1i_grant_count_out            (l1i_grant_count_out),
        .l1d_grant_count_out            (l1d_grant_count_out),
        .contention_count_out           (contention_count_out)
`endif
    );

    typedef struct {
        logic [31:0]       addr;
        memory_operation_e op;
        logic [127:0]      data;
    } l2_req_t;

    typedef struct {
        int           port;
        logic [127:0] line;
    } rsp_t;

    int      acc_q[$];
    l2_req_t l2_q[$];
    rsp_t    rsp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int l2_lat   = 3;
    bit rsp_busy = 1'b0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // L2 model returns a line derived from the request address
    function automatic logic [127:0] line_for(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0] ^ 8'hE5;
        return {16{b}};
    endfunction

    task automatic cyc();
        @(posedge clk_in);
        #2;
    endtask

    task automatic expect_txn(input int port, input logic [31:0] a, input memory_operation_e op,
                              input logic [127:0] d);
        l2_req_t r;
        rsp_t    s;
        r.addr = a;
        r.op   = op;
        r.data = d;
        acc_q.push_back(port);
        l2_q.push_back(r);
        if (op == Load) begin
            s.port = port;
            s.line = line_for(a);
            rsp_q.push_back(s);
        end
    endtask

    task automatic req(input int port, input logic [31:0] a, input memory_operation_e op,
                       input logic [127:0] d);
        bit done = 1'b0;
        cyc();
        if (port == 0) begin
            l1i_request_valid_in = 1'b1; l1i_request_address_in = a;
            l1i_request_operation_in = op; l1i_request_data_in = d;
        end else begin
            l1d_request_valid_in = 1'b1; l1d_request_address_in = a;
            l1d_request_operation_in = op; l1d_request_data_in = d;
        end
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_in);
            if ((port == 0) ? l1i_request_ready_out : l1d_request_ready_out) begin
                done = 1'b1;
                break;
            end
        end
        cyc();
        if (port == 0) l1i_request_valid_in = 1'b0;
        else           l1d_request_valid_in = 1'b0;
        check_eq("req_accept", 128'(done), 128'(1));
    endtask

    task automatic wait_quiet();
        bit ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_in);
            if (acc_q.size() == 0 && l2_q.size() == 0 && rsp_q.size() == 0 &&
                !l2_cache_request_valid_out && !l2_cache_response_ready_out &&
                !l1i_response_valid_out && !l1d_response_valid_out) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("quiet", 128'(ok), 128'(1));
    endtask

    task automatic pop_acc(input int port);
        if (acc_q.size() == 0) check_eq("acc_underflow", 128'(port), 128'(-1));
        else check_eq("grant_port", 128'(port), 128'(acc_q.pop_front()));
    endtask

    task automatic pop_rsp(input int port, input logic [127:0] data);
        rsp_t s;
        if (rsp_q.size() == 0) begin
            check_eq("rsp_underflow", 128'(port), 128'(-1));
        end else begin
            s = rsp_q.pop_front();
            check_eq("rsp_port", 128'(port), 128'(s.port));
            check_eq("rsp_data", data, s.line);
        end
    endtask

    // Monitor: retires scoreboard entries on every handshake it observes
    initial begin
        l2_req_t e;
        forever begin
            @(negedge clk_in);
            if (!rst_in) begin
                if (l1i_request_ready_out && l1d_request_ready_out)
                    check_eq("dual_ready", 128'(1), 128'(0));
                if (l1i_request_ready_out && l1i_request_valid_in) pop_acc(0);
                if (l1d_request_ready_out && l1d_request_valid_in) pop_acc(1);
                if (l2_cache_request_valid_out && l2_cache_request_ready_in) begin
                    if (l2_q.size() == 0) begin
                        check_eq("l2q_underflow", 128'(1), 128'(0));
                    end else begin
                        e = l2_q.pop_front();
                        check_eq("l2_addr", 128'(l2_cache_request_address_out), 128'(e.addr));
                        check_eq("l2_op", 128'(l2_cache_request_operation_out), 128'(e.op));
                        check_eq("l2_data", l2_cache_request_data_out, e.data);
                    end
                end
                if (l1i_response_valid_out && l1i_response_ready_in)
                    pop_rsp(0, l1i_response_data_out);
                if (l1d_response_valid_out && l1d_response_ready_in)
                    pop_rsp(1, l1d_response_data_out);
            end
        end
    end

    // L2 responder: answers each accepted LOAD after l2_lat cycles
    initial begin
        logic [127:0] line;
        forever begin
            @(negedge clk_in);
            if (!rst_in && l2_cache_request_valid_out && l2_cache_request_ready_in &&
                l2_cache_request_operation_out == Load) begin
                rsp_busy = 1'b1;
                line = line_for(l2_cache_request_address_out);
                repeat (l2_lat) @(posedge clk_in);
                #2;
                l2_cache_response_valid_in = 1'b1;
                l2_cache_response_data_in  = line;
                for (int k = 0; k < 60; k++) begin
                    @(negedge clk_in);
                    if (l2_cache_response_ready_out) break;
                end
                @(posedge clk_in);
                #2;
                l2_cache_response_valid_in = 1'b0;
                l2_cache_response_data_in  = '0;
                rsp_busy = 1'b0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_l2_valid"}, 128'(l2_cache_request_valid_out), 128'(0));
        check_eq({tag, "_l2_rsp_ready"}, 128'(l2_cache_response_ready_out), 128'(0));
        check_eq({tag, "_l2_addr"}, 128'(l2_cache_request_address_out), 128'(0));
        check_eq({tag, "_l2_op"}, 128'(l2_cache_request_operation_out), 128'(Load));
        check_eq({tag, "_l2_data"}, l2_cache_request_data_out, 128'(0));
        check_eq({tag, "_readies"}, 128'({l1i_request_ready_out, l1d_request_ready_out}), 128'(0));
        check_eq({tag, "_rsp_valids"}, 128'({l1i_response_valid_out, l1d_response_valid_out}),
                 128'(0));
        check_eq({tag, "_rsp_data"}, l1i_response_data_out | l1d_response_data_out, 128'(0));
    endtask

    task automatic pulse_reset();
        bit idle_ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (!rsp_busy) begin
                idle_ok = 1'b1;
                break;
            end
            cyc();
        end
        check_eq("responder_idle", 128'(idle_ok), 128'(1));
        cyc();
        rst_in = 1'b1;
        cyc();
        cyc();
        rst_in = 1'b0;
    endtask

    initial begin
        logic [127:0] st_data;
        bit           seen;
        st_data = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;

        // Reset state
        #1 rst_in = 1'b1;
        #2 check_reset_outputs("reset");
        cyc();
        cyc();
        rst_in = 1'b0;

        // Port 0 LOAD only, L2 answers 3 cycles later
        l2_lat = 3;
        cyc();
        l1i_request_valid_in = 1'b1; l1i_request_address_in = 32'h0000_1040;
        l1i_request_operation_in = Load; l1i_request_data_in = '0;
        expect_txn(0, 32'h0000_1040, Load, '0);
        @(negedge clk_in);
        check_eq("t1_ready", 128'(l1i_request_ready_out), 128'(1));
        check_eq("t1_l2_not_yet", 128'(l2_cache_request_valid_out), 128'(0));
        cyc();
        l1i_request_valid_in = 1'b0;
        @(negedge clk_in);
        check_eq("t1_l2_valid", 128'(l2_cache_request_valid_out), 128'(1));
        check_eq("t1_l2_addr", 128'(l2_cache_request_address_out), 128'(32'h0000_1040));
        check_eq("t1_l2_op", 128'(l2_cache_request_operation_out), 128'(Load));
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_in);
            if (l1i_response_valid_out) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("t1_rsp_seen", 128'(seen), 128'(1));
        check_eq("t1_rsp_line", l1i_response_data_out, {16{8'hA5}});
        check_eq("t1_l1d_valid", 128'(l1d_response_valid_out), 128'(0));
        check_eq("t1_l1d_data", l1d_response_data_out, 128'(0));
        wait_quiet();

        // Port 1 STORE with L2 stalling for 5 cycles
        l2_cache_request_ready_in = 1'b0;
        expect_txn(1, 32'h0000_2000, Store, st_data);
        req(1, 32'h0000_2000, Store, st_data);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_in);
            check_eq("t2_hold_valid", 128'(l2_cache_request_valid_out), 128'(1));
            check_eq("t2_hold_addr", 128'(l2_cache_request_address_out), 128'(32'h0000_2000));
            check_eq("t2_hold_op", 128'(l2_cache_request_operation_out), 128'(Store));
            check_eq("t2_hold_data", l2_cache_request_data_out, st_data);
            cyc();
        end
        l2_cache_request_ready_in = 1'b1;
        cyc();
        @(negedge clk_in);
        check_eq("t2_back_idle", 128'(l2_cache_request_valid_out), 128'(0));
        check_eq("t2_no_rsp", 128'({l1i_response_valid_out, l1d_response_valid_out}), 128'(0));
        expect_txn(0, 32'h0000_5000, Store, ~st_data);
        req(0, 32'h0000_5000, Store, ~st_data);
        wait_quiet();

        // Response backpressure on the data L1
        l2_lat = 2;
        l1d_response_ready_in = 1'b0;
        expect_txn(1, 32'h0000_3080, Load, '0);
        expect_txn(0, 32'h0000_4000, Store, st_data);
        req(1, 32'h0000_3080, Load, '0);
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_in);
            if (l1d_response_valid_out) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("t4_rsp_seen", 128'(seen), 128'(1));
        fork
            req(0, 32'h0000_4000, Store, st_data);
        join_none
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            check_eq("t4_hold_valid", 128'(l1d_response_valid_out), 128'(1));
            check_eq("t4_hold_data", l1d_response_data_out, line_for(32'h0000_3080));
            check_eq("t4_l2_rsp_ready", 128'(l2_cache_response_ready_out), 128'(0));
            check_eq("t4_l1i_blocked", 128'(l1i_request_ready_out), 128'(0));
        end
        cyc();
        l1d_response_ready_in = 1'b1;
        wait_quiet();
        cyc();

        // Reset asserted between edges while waiting on L2
        l2_lat = 10;
        acc_q.push_back(0);
        begin
            l2_req_t r;
            r.addr = 32'h0000_6000; r.op = Load; r.data = '0;
            l2_q.push_back(r);
        end
        req(0, 32'h0000_6000, Load, '0);
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_in);
            if (l2_cache_response_ready_out) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("t5_in_wait", 128'(seen), 128'(1));
        #1 rst_in = 1'b1;
        #1 check_reset_outputs("t5_async");
        cyc();
        cyc();
        rst_in = 1'b0;
        expect_txn(1, 32'h0000_7000, Store, st_data);
        req(1, 32'h0000_7000, Store, st_data);
        wait_quiet();

        // Contended LOAD pairs after reset: strict alternation starting at port 0
        pulse_reset();
        l2_lat = 1;
        for (int p = 0; p < 3; p++) begin
            logic [31:0] ai;
            logic [31:0] ad;
            ai = 32'h0001_0010 + 32'(p * 32);
            ad = 32'h0002_0020 + 32'(p * 32);
            expect_txn(0, ai, Load, '0);
            expect_txn(1, ad, Load, '0);
            fork
                req(0, ai, Load, '0);
                req(1, ad, Load, '0);
            join
            wait_quiet();
        end
`ifdef L2_ARBITER_PERF_EN
        check_eq("perf_l1i", 128'(l1i_grant_count_out), 128'(3));
        check_eq("perf_l1d", 128'(l1d_grant_count_out), 128'(3));
        check_eq("perf_contention", 128'(contention_count_out), 128'(3));
`endif

        check_eq("acc_q_empty", 128'(acc_q.size()), 128'(0));
        check_eq("l2_q_empty", 128'(l2_q.size()), 128'(0));
        check_eq("rsp_q_empty", 128'(rsp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
